i2s_rx: RTL and testbench
=========================

# i2s_rx

Serial audio receiver: deserializes a Philips-format I2S stream (bit clock, word select, data) driven by an external transmitter into parallel left/right samples in the `clk_sys` domain. It is the receive-side counterpart of the core's I2S audio transmitter and is used to feed external audio (tape input, loopback test) into the core. All three I2S inputs are asynchronous to `clk_sys`; they are oversampled and never used as clocks.

## Interface
- `SAMPLE_W`, 16, output sample width in bits (8..32).
- `SYNC_STAGES`, 2, synchronizer flops per I2S input (≥2).

- `clk_sys` in 1: system clock; must be ≥4× `sclk` frequency.
- `reset_n` in 1: synchronous, active-low reset.
- `sclk` in 1: I2S bit clock; async.
- `lrclk` in 1: I2S word select; 0 = left, 1 = right; async.
- `sdata` in 1: I2S serial data, MSB first; async.
- `left_chan` out SAMPLE_W: last complete left sample, two's complement.
- `right_chan` out SAMPLE_W: last complete right sample.
- `sample_valid` out 1: one-cycle pulse when `left_chan`/`right_chan` update.
- `frame_err` out 1: one-cycle pulse on a rejected frame (only with `I2S_RX_FRAMECHK_EN`, else constant 0).

## Operation
- `sclk`, `lrclk`, `sdata` each pass through `SYNC_STAGES` flops plus one delay flop. A bit event is a synchronized `sclk` 0→1 transition; `lrclk` and `sdata` are sampled from the same stage at that event.
- I2S timing: data lags word select by one bit. On a bit event where synchronized `lrclk` differs from its value at the previous bit event (boundary event), the sampled `sdata` is the LSB of the *previous* channel; the MSB of the new channel arrives on the next bit event.
- Bit counter `cnt` (6 bits, saturates at 63) per half-frame. On every bit event belonging to the current channel (including the boundary event that closes it): if `cnt < SAMPLE_W`, write the bit at position `SAMPLE_W-1-cnt` of a working register cleared at channel start; then `cnt++`. Bits beyond `SAMPLE_W` are discarded (truncation); fewer bits leave LSBs zero (left-justified, zero-padded).
- States:
  - SYNC (reset state): ignore data; on boundary event with `lrclk` 1→0, go LEFT, clear working register, `cnt=0`.
  - LEFT: on boundary event 0→1, copy working register to left holding register, go RIGHT, clear working register, `cnt=0`.
  - RIGHT: on boundary event 1→0, load `left_chan` ← left holding, `right_chan` ← working register, pulse `sample_valid`, go LEFT, clear, `cnt=0`.
- Outputs change only together with `sample_valid`; both channels always belong to the same frame.

## Timing
- Reset values: `left_chan`=0, `right_chan`=0, `sample_valid`=0, `frame_err`=0, state SYNC, `cnt`=0.
- Latency: `sample_valid` is high during the clk_sys cycle beginning exactly `SYNC_STAGES+2` clk_sys edges after the first clk_sys edge that samples `sclk` high for the closing boundary event; outputs valid the same cycle.
- `sample_valid` never high on two consecutive cycles.
- `reset_n` low mid-frame: on the next clk_sys edge all state and outputs take reset values; partial frame discarded; first output after release requires a full left+right frame following a 1→0 `lrclk` boundary.
- `lrclk` toggling with no `sclk` edges: no effect (only bit events are evaluated).

## Configuration
- `I2S_RX_FRAMECHK_EN` defined: at each boundary event, if total bits in the closing channel (`cnt` after increment) < `SAMPLE_W`, the frame is bad; on the RIGHT→LEFT boundary of a bad frame (either channel short), `sample_valid` is suppressed, outputs hold, `frame_err` pulses in the cycle `sample_valid` would have. State machine continues to LEFT.
- Not defined: no check; short channels are delivered zero-padded; `frame_err` tied 0.

## Test plan
- Reset: hold `reset_n`=0 4 cycles with stream active → all outputs 0, no `sample_valid` until one full frame after the first 1→0 `lrclk` boundary.
- 16-bit slots, left=0x8001, right=0x7FFE, `sclk`=clk_sys/8 → `sample_valid` once per frame, `left_chan`=0x8001, `right_chan`=0x7FFE, latency `SYNC_STAGES+2` cycles.
- 32-bit slots, left MSW 0x1234 then 0xFFFF, right MSW 0xABCD → outputs 0x1234/0xABCD (truncation).
- 12-bit slots, left 0xABC, right 0x123: without macro → 0xABC0/0x1230 with `sample_valid`; with macro → no `sample_valid`, `frame_err` pulse, outputs unchanged.
- Assert `reset_n`=0 for 1 cycle mid right channel → outputs 0 immediately, next frame decoded correctly after resync.
- Start stream with `lrclk`=1 (mid right channel) → first partial frame ignored, first `sample_valid` carries the first complete left+right pair.

Source files
------------

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - Philips I2S receiver oversampled in clk_sys; optional frame check via I2S_RX_FRAMECHK_EN
module i2s_rx #(
    parameter int SAMPLE_W    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                sclk,
    input  logic                lrclk,
    input  logic                sdata,
    output logic [SAMPLE_W-1:0] left_chan,
    output logic [SAMPLE_W-1:0] right_chan,
    output logic                sample_valid,
    output logic                frame_err
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    // Single set bit at the MSB; shifted right by the bit count it marks the write position.
    // Once the count reaches SAMPLE_W the mask becomes zero, which truncates longer slots.
    localparam logic [SAMPLE_W-1:0] MSB_ONE = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] lr_sync_q;
    logic [SYNC_STAGES-1:0] sd_sync_q;
    logic                   sclk_dly_q;

    logic                   bit_evt_q;
    logic                   lr_bit_q;
    logic                   sd_bit_q;
    logic                   prev_lr_q;

    state_t                 state_q;
    state_t                 state_d;

    logic                   boundary;
    logic                   accum;
    logic                   chan_start;
    logic                   close_left;
    logic                   close_right;
    logic                   deliver_ok;

    logic [5:0]             cnt_q;
    logic [5:0]             cnt_inc;
    logic [SAMPLE_W-1:0]    bit_mask;
    logic [SAMPLE_W-1:0]    work_q;
    logic [SAMPLE_W-1:0]    work_bit;
    logic [SAMPLE_W-1:0]    left_hold_q;
    logic [SAMPLE_W-1:0]    pend_left_q;
    logic [SAMPLE_W-1:0]    pend_right_q;
    logic                   deliver_q;

    logic [SAMPLE_W-1:0]    left_chan_q;
    logic [SAMPLE_W-1:0]    right_chan_q;
    logic                   sample_valid_q;

    // Synchronize the three asynchronous I2S inputs plus the sclk delay flop for edge detection
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            lr_sync_q   <= '0;
            sd_sync_q   <= '0;
            sclk_dly_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            lr_sync_q   <= {lr_sync_q[SYNC_STAGES-2:0], lrclk};
            sd_sync_q   <= {sd_sync_q[SYNC_STAGES-2:0], sdata};
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    // Register the bit event together with lrclk/sdata taken from the same synchronizer stage
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            bit_evt_q <= 1'b0;
            lr_bit_q  <= 1'b0;
            sd_bit_q  <= 1'b0;
            prev_lr_q <= 1'b0;
        end else begin
            bit_evt_q <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;
            lr_bit_q  <= lr_sync_q[SYNC_STAGES-1];
            sd_bit_q  <= sd_sync_q[SYNC_STAGES-1];
            if (bit_evt_q) begin
                prev_lr_q <= lr_bit_q;
            end
        end
    end

    // A boundary is a bit event whose word select differs from the previous bit event
    assign boundary = bit_evt_q && (lr_bit_q != prev_lr_q);

    // Channel state register
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: only 1->0 boundaries enter LEFT, only 0->1 boundaries enter RIGHT
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC:  if (boundary && !lr_bit_q) state_d = ST_LEFT;
            ST_LEFT:  if (boundary && lr_bit_q)  state_d = ST_RIGHT;
            ST_RIGHT: if (boundary && !lr_bit_q) state_d = ST_LEFT;
            default:  state_d = ST_SYNC;
        endcase
    end

    // Output decode: which datapath action the current bit event triggers
    always_comb begin
        accum       = 1'b0;
        chan_start  = 1'b0;
        close_left  = 1'b0;
        close_right = 1'b0;
        case (state_q)
            ST_SYNC: begin
                chan_start = boundary && !lr_bit_q;
            end
            ST_LEFT: begin
                accum      = bit_evt_q;
                close_left = boundary && lr_bit_q;
                chan_start = close_left;
            end
            ST_RIGHT: begin
                accum       = bit_evt_q;
                close_right = boundary && !lr_bit_q;
                chan_start  = close_right;
            end
            default: begin
                accum = 1'b0;
            end
        endcase
    end

    assign cnt_inc  = (cnt_q == 6'd63) ? 6'd63 : cnt_q + 6'd1;
    assign bit_mask = MSB_ONE >> cnt_q;
    // Working register including the bit of the current event (the closing LSB on a boundary)
    assign work_bit = sd_bit_q ? (work_q | bit_mask) : work_q;

`ifdef I2S_RX_FRAMECHK_EN
    localparam logic [6:0] SAMPLE_W_L = 7'(SAMPLE_W);

    logic chan_short;
    logic frame_bad;
    logic left_short_q;
    logic err_q;
    logic frame_err_q;

    assign chan_short = ({1'b0, cnt_inc} < SAMPLE_W_L);
    assign frame_bad  = left_short_q | chan_short;
    assign deliver_ok = close_right & ~frame_bad;
    assign frame_err  = frame_err_q;

    // Remember a short left channel and flag the frame when the right channel closes
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            left_short_q <= 1'b0;
            err_q        <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            if (close_left) begin
                left_short_q <= chan_short;
            end
            err_q       <= close_right & frame_bad;
            frame_err_q <= err_q;
        end
    end
`else
    assign deliver_ok = close_right;
    assign frame_err  = 1'b0;
`endif

    // Bit accumulation, left holding register and the frame handed to the output stage
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            work_q       <= '0;
            left_hold_q  <= '0;
            pend_left_q  <= '0;
            pend_right_q <= '0;
            deliver_q    <= 1'b0;
        end else begin
            if (chan_start) begin
                cnt_q  <= '0;
                work_q <= '0;
            end else if (accum) begin
                cnt_q  <= cnt_inc;
                work_q <= work_bit;
            end
            if (close_left) begin
                left_hold_q <= work_bit;
            end
            if (deliver_ok) begin
                pend_left_q  <= left_hold_q;
                pend_right_q <= work_bit;
            end
            deliver_q <= deliver_ok;
        end
    end

    // Output registers update only together with sample_valid so both channels stay paired
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            left_chan_q    <= '0;
            right_chan_q   <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            if (deliver_q) begin
                left_chan_q  <= pend_left_q;
                right_chan_q <= pend_right_q;
            end
            sample_valid_q <= deliver_q;
        end
    end

    assign left_chan    = left_chan_q;
    assign right_chan   = right_chan_q;
    assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - scoreboard bench for i2s_rx
module tb_i2s_rx;

    localparam int SW = 16;
    localparam int SS = 2;
`ifdef I2S_RX_FRAMECHK_EN
    localparam bit FRAMECHK = 1'b1;
`else
    localparam bit FRAMECHK = 1'b0;
`endif

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          sclk    = 1'b0;
    logic          lrclk   = 1'b1;
    logic          sdata   = 1'b0;
    logic [SW-1:0] left_chan;
    logic [SW-1:0] right_chan;
    logic          sample_valid;
    logic          frame_err;

    i2s_rx #(.SAMPLE_W(SW), .SYNC_STAGES(SS)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .sclk         (sclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .left_chan    (left_chan),
        .right_chan   (right_chan),
        .sample_valid (sample_valid),
        .frame_err    (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [SW-1:0] l;
        logic [SW-1:0] r;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t sbq[$];

    // Reference channel tracker (0 = sync, 1 = left, 2 = right)
    int            m_trk    = 0;
    logic          m_prev   = 1'b0;
    logic [SW-1:0] m_left   = '0;
    logic          m_lshort = 1'b0;
    logic [SW-1:0] prev_exp = '0;
    int            prev_n   = 0;
    logic          pend_bit = 1'b0;
    logic [SW-1:0] last_l   = '0;
    logic [SW-1:0] last_r   = '0;

    function automatic logic [SW-1:0] trunc(input logic [31:0] v, input int n);
        if (n >= SW) return SW'(v >> (n - SW));
        else         return SW'(v << (SW - n));
    endfunction

    task automatic model_event(input logic ws);
        exp_t e;
        if (ws != m_prev) begin
            if (m_trk == 0 && !ws) begin
                m_trk = 1;
            end else if (m_trk == 1 && ws) begin
                m_left   = prev_exp;
                m_lshort = (prev_n < SW);
                m_trk    = 2;
            end else if (m_trk == 2 && !ws) begin
                e.l   = m_left;
                e.r   = prev_exp;
                e.err = FRAMECHK && (m_lshort || (prev_n < SW));
                e.cyc = cyc + 1 + SS + 2;
                sbq.push_back(e);
                m_trk = 1;
            end
        end
        m_prev = ws;
    endtask

    task automatic send_bit(input logic ws, input logic d);
        lrclk = ws;
        sdata = d;
        repeat (4) @(posedge clk_sys);
        #1;
        model_event(ws);
        sclk = 1'b1;
        repeat (4) @(posedge clk_sys);
        #1;
        sclk = 1'b0;
    endtask

    task automatic pulse_reset();
        repeat (4) @(posedge clk_sys);
        #1;
        reset_n = 1'b0;
        @(posedge clk_sys);
        #1;
        chk("rst_mid_left", 32'(left_chan), 32'd0);
        chk("rst_mid_right", 32'(right_chan), 32'd0);
        reset_n  = 1'b1;
        m_trk    = 0;
        m_prev   = 1'b0;
        last_l   = '0;
        last_r   = '0;
    endtask

    // One slot: event 0 carries the previous word's LSB, then MSB..bit1 of this word
    task automatic send_word(input logic ws, input logic [31:0] val, input int n, input int rst_at);
        send_bit(ws, pend_bit);
        prev_exp = trunc(val, n);
        prev_n   = n;
        for (int i = 1; i < n; i++) begin
            if (i == rst_at) pulse_reset();
            send_bit(ws, val[n-i]);
        end
        pend_bit = val[0];
    endtask

    task automatic toggle_lr_idle();
        logic s;
        s = lrclk;
        for (int i = 0; i < 3; i++) begin
            lrclk = ~lrclk;
            repeat (2) @(posedge clk_sys);
        end
        lrclk = s;
    endtask

    logic sv_prev = 1'b0;

    // Scoreboard side: every output pulse must match the oldest expected frame
    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (sample_valid || frame_err) begin
                if (sbq.size() == 0) begin
                    chk("spurious_pulse", {30'd0, frame_err, sample_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("pulse_kind", {30'd0, frame_err, sample_valid},
                        e.err ? 32'd2 : 32'd1);
                    chk("latency", 32'(cyc), 32'(e.cyc));
                    if (e.err) begin
                        chk("hold_left", 32'(left_chan), 32'(last_l));
                        chk("hold_right", 32'(right_chan), 32'(last_r));
                    end else begin
                        chk("left", 32'(left_chan), 32'(e.l));
                        chk("right", 32'(right_chan), 32'(e.r));
                        last_l = e.l;
                        last_r = e.r;
                    end
                end
            end
            if (sample_valid) chk("sv_gap", {31'd0, sv_prev}, 32'd0);
        end
        sv_prev = sample_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] r1;
        logic [31:0] r2;
        fork
            begin
                repeat (4) @(posedge clk_sys);
                #1;
                chk("rst_left", 32'(left_chan), 32'd0);
                chk("rst_right", 32'(right_chan), 32'd0);
                chk("rst_valid", {31'd0, sample_valid}, 32'd0);
                chk("rst_ferr", {31'd0, frame_err}, 32'd0);
                reset_n = 1'b1;
            end
            send_word(1'b1, 32'hDEADBEEF, 32, -1);
        join
        chk("idle_left", 32'(left_chan), 32'd0);
        chk("idle_right", 32'(right_chan), 32'd0);

        send_word(1'b0, 32'h8001, 16, -1);
        send_word(1'b1, 32'h7FFE, 16, -1);
        send_word(1'b0, 32'h8001, 16, -1);
        send_word(1'b1, 32'h7FFE, 16, -1);
        toggle_lr_idle();
        send_word(1'b0, 32'h1234FFFF, 32, -1);
        send_word(1'b1, 32'hABCD5A5A, 32, -1);
        send_word(1'b0, 32'h00000ABC, 12, -1);
        send_word(1'b1, 32'h00000123, 12, -1);
        send_word(1'b0, 32'h0F0F, 16, -1);
        send_word(1'b1, 32'hF0F0, 16, -1);
        send_word(1'b0, 32'h1111, 16, -1);
        send_word(1'b1, 32'h2222, 16, 6);
        for (int k = 0; k < 3; k++) begin
            r1 = $urandom & 32'hFFFF;
            r2 = $urandom & 32'hFFFF;
            send_word(1'b0, r1, 16, -1);
            send_word(1'b1, r2, 16, -1);
        end
        toggle_lr_idle();
        send_word(1'b0, 32'h0089ABCD, 24, -1);
        send_word(1'b1, 32'h00765432, 24, -1);
        send_word(1'b0, 32'h5555, 16, -1);
        repeat (20) @(posedge clk_sys);
        #1;
        chk("drain", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
